// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF measurement controller.
// Holds the FSM state encoding and the width helpers used by the top and the phase timer.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_SETTLE,
      ST_COMPARE,
      ST_DONE
   } state_t;

   localparam int DEF_WINDOW_CYCLES = 100000;
   localparam int DEF_CLR_CYCLES    = 4;
   localparam int DEF_SETTLE_CYCLES = 4;

   // Never returns less than 1 so that degenerate sizes still give a legal vector.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1)
         r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int sel_w(input int num_ro);
      return clog2(num_ro);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ro_puf_phase_timer.sv
// Loadable down-counter that times the CLEAR, RUN and SETTLE phases.
// expire flags the last cycle of a phase; the counter parks at zero when not reloaded.
module ro_puf_phase_timer #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         expire
);

   always_ff @(posedge clk) begin
      if (!reset_n)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (value != '0)
         value <= value - 1'b1;
   end

   assign expire = (value == W'(1));

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// Sequences RO-pair selection, counter clear, gated count window and compare for
// each response bit, then reports the response and tie mask with a done pulse.
module ro_puf_meas_ctrl
   import ro_puf_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter int NUM_RO        = 16,
   parameter int RESP_BITS     = 8,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SEL_W         = sel_w(NUM_RO)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
   output logic [SEL_W-1:0]             ro_sel_a,
   output logic [SEL_W-1:0]             ro_sel_b,
   output logic                         ro_en,
   output logic                         cnt_clr_n,
   input  logic [CNT_W-1:0]             cnt_a,
   input  logic [CNT_W-1:0]             cnt_b,
   output logic                         busy,
   output logic                         done,
   output logic [RESP_BITS-1:0]         response,
   output logic [RESP_BITS-1:0]         tie_mask
);

   localparam int TW = clog2(max3(WINDOW_CYCLES, CLR_CYCLES, SETTLE_CYCLES) + 1);
   localparam int IW = clog2(RESP_BITS);
   localparam int CH = RESP_BITS * 2 * SEL_W;

   state_t                 state;
   logic [CH-1:0]          chal_q;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          idx_nxt;
   logic                   tmr_load;
   logic [TW-1:0]          tmr_val;
   logic [TW-1:0]          tmr_value;
   logic                   tmr_expire;
   logic                   phase_end;

   assign idx_nxt = idx + 1'b1;

   // A timer sitting at zero inside a timed phase also ends it, so the FSM cannot stall.
   assign phase_end = tmr_expire || (tmr_value == '0);

   ro_puf_phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: if (start) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(CLR_CYCLES);
         end
         ST_CLEAR: if (phase_end) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(WINDOW_CYCLES);
         end
         ST_RUN: if (phase_end) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(SETTLE_CYCLES);
         end
         ST_COMPARE: if (idx != IW'(RESP_BITS - 1)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(CLR_CYCLES);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         chal_q    <= '0;
         idx       <= '0;
         ro_sel_a  <= '0;
         ro_sel_b  <= '0;
         ro_en     <= 1'b0;
         cnt_clr_n <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         response  <= '0;
         tie_mask  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               ro_en     <= 1'b0;
               cnt_clr_n <= 1'b0;
               if (start) begin
                  chal_q    <= challenge;
                  response  <= '0;
                  tie_mask  <= '0;
                  idx       <= '0;
                  ro_sel_a  <= challenge[0 +: SEL_W];
                  ro_sel_b  <= challenge[SEL_W +: SEL_W];
                  // Counter reset is synchronous to the RO clock, so the ROs run during clear.
                  ro_en     <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: if (phase_end) begin
               cnt_clr_n <= 1'b1;
               state     <= ST_RUN;
            end
            ST_RUN: if (phase_end) begin
               ro_en <= 1'b0;
               state <= ST_SETTLE;
            end
            ST_SETTLE: if (phase_end)
               state <= ST_COMPARE;
            ST_COMPARE: begin
               response[idx] <= (cnt_a > cnt_b);
               tie_mask[idx] <= (cnt_a == cnt_b);
               cnt_clr_n     <= 1'b0;
               if (idx == IW'(RESP_BITS - 1)) begin
                  state <= ST_DONE;
               end else begin
                  idx      <= idx_nxt;
                  ro_sel_a <= chal_q[2*SEL_W*int'(idx_nxt) +: SEL_W];
                  ro_sel_b <= chal_q[2*SEL_W*int'(idx_nxt) + SEL_W +: SEL_W];
                  ro_en    <= 1'b1;
                  state    <= ST_CLEAR;
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Bench for ro_puf_meas_ctrl: ROs modelled as fixed-period edge sources feeding
// two counters; a scoreboard checks each response against RO speed ordering.
module tb_ro_puf_meas_ctrl;

   localparam int RB  = 4;
   localparam int WIN = 20;
   localparam int CLR = 2;
   localparam int SET = 2;
   localparam int NRO = 16;
   localparam int SW  = 4;
   localparam int CW  = 16;
   localparam int CH  = RB * 2 * SW;
   localparam int LAT = RB * (CLR + WIN + SET + 1) + 1;

   typedef struct {
      logic [RB-1:0] resp;
      logic [RB-1:0] tie;
      int            start_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [CH-1:0] challenge = '0;
   logic [SW-1:0] ro_sel_a, ro_sel_b;
   logic          ro_en, cnt_clr_n;
   logic [CW-1:0] cnt_a = '0;
   logic [CW-1:0] cnt_b = '0;
   logic          busy, done;
   logic [RB-1:0] response, tie_mask;

   ro_puf_meas_ctrl #(
      .CNT_W(CW), .NUM_RO(NRO), .RESP_BITS(RB), .WINDOW_CYCLES(WIN),
      .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET), .SEL_W(SW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
      .ro_sel_a(ro_sel_a), .ro_sel_b(ro_sel_b), .ro_en(ro_en), .cnt_clr_n(cnt_clr_n),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy), .done(done),
      .response(response), .tie_mask(tie_mask)
   );

   // RO periods in ticks; lower index is faster and neighbours differ by several counts per window.
   int per [NRO] = '{10, 11, 13, 14, 16, 18, 20, 22, 25, 28, 31, 35, 39, 44, 49, 55};

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   tick = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   exp_t last_exp;

   initial forever #100 clk = ~clk;
   always @(posedge clk) cyc++;

   // Ticks land on odd times, clock edges on even ones, so there is no race with the DUT.
   initial begin
      #1;
      forever begin
         #2;
         tick++;
         if (ro_en === 1'b1) begin
            if (tick % per[ro_sel_a] == 0) begin
               if (!cnt_clr_n) cnt_a = '0; else cnt_a = cnt_a + 1'b1;
            end
            if (tick % per[ro_sel_b] == 0) begin
               if (!cnt_clr_n) cnt_b = '0; else cnt_b = cnt_b + 1'b1;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   function automatic exp_t model(input logic [CH-1:0] ch, input int sc);
      exp_t e;
      e.resp = '0;
      e.tie  = '0;
      for (int i = 0; i < RB; i++) begin
         int a, b;
         a = int'(ch[2*SW*i +: SW]);
         b = int'(ch[2*SW*i + SW +: SW]);
         e.resp[i] = per[a] < per[b];
         e.tie[i]  = (a == b);
      end
      e.start_cyc = sc;
      return e;
   endfunction

   function automatic logic [CH-1:0] mk(input int a0, input int b0, input int a1, input int b1,
                                        input int a2, input int b2, input int a3, input int b3);
      return {SW'(b3), SW'(a3), SW'(b2), SW'(a2), SW'(b1), SW'(a1), SW'(b0), SW'(a0)};
   endfunction

   int            done_cnt = 0;
   int            en_cnt = 0;
   int            clr_cnt = 0;
   int            busy_cnt = 0;
   logic          prev_en = 1'b0;
   logic [SW-1:0] prev_a = '0;
   logic [SW-1:0] prev_b = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         en_cnt = 0; clr_cnt = 0; busy_cnt = 0; prev_en = 1'b0;
      end else begin
         if (ro_en) en_cnt++;
         if (ro_en && !cnt_clr_n) clr_cnt++;
         if (busy) busy_cnt++;
         if (ro_en && prev_en) begin
            check("sel_a_stable", ro_sel_a, prev_a);
            check("sel_b_stable", ro_sel_b, prev_b);
         end
         prev_en = ro_en;
         prev_a  = ro_sel_a;
         prev_b  = ro_sel_b;
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done at cycle %0d", cyc);
            end else begin
               mon_e = sb_q.pop_front();
               check("response", response, mon_e.resp);
               check("tie_mask", tie_mask, mon_e.tie);
               check("latency", cyc - mon_e.start_cyc, LAT);
               check("busy_at_done", busy, 0);
               check("ro_en_cycles", en_cnt, (CLR + WIN) * RB);
               check("clr_cycles", clr_cnt, CLR * RB);
               check("busy_cycles", busy_cnt, LAT);
            end
            en_cnt = 0; clr_cnt = 0; busy_cnt = 0;
         end
      end
   end

   task automatic run(input logic [CH-1:0] ch, input bit inject);
      int d0;
      @(negedge clk);
      challenge = ch;
      start = 1'b1;
      last_exp = model(ch, cyc + 1);
      sb_q.push_back(last_exp);
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      challenge = $urandom;
      if (inject) begin
         repeat (10) @(negedge clk);
         start = 1'b1;
         challenge = $urandom;
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 400 && done_cnt == d0; k++) @(negedge clk);
      check("done_seen", done_cnt - d0, 1);
      @(negedge clk);
   endtask

   initial begin
      logic [CH-1:0] ch;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ro_en", ro_en, 0);
      check("rst_cnt_clr_n", cnt_clr_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_response", response, 0);
      check("rst_tie_mask", tie_mask, 0);
      check("rst_sel", {ro_sel_a, ro_sel_b}, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_ro_en", ro_en, 0);
      check("idle_cnt_clr_n", cnt_clr_n, 0);
      check("idle_busy", busy, 0);
      check("idle_response", response, 0);

      run(mk(0, 1, 2, 3, 4, 5, 6, 7), 1'b0);
      run(mk(1, 0, 3, 2, 5, 4, 7, 6), 1'b0);
      run(mk(0, 1, 2, 3, 3, 3, 6, 7), 1'b0);
      run(mk(8, 9, 15, 2, 12, 11, 0, 14), 1'b1);

      // Abort during the RUN phase of bit 1.
      @(negedge clk);
      challenge = mk(0, 1, 2, 3, 4, 5, 6, 7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (34) @(negedge clk);
      check("pre_reset_ro_en", ro_en, 1);
      check("pre_reset_cnt_clr_n", cnt_clr_n, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_ro_en", ro_en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt_clr_n", cnt_clr_n, 0);
      check("midrst_response", response, 0);
      reset_n = 1'b1;
      run(mk(0, 1, 2, 3, 4, 5, 6, 7), 1'b0);

      for (int r = 0; r < 4; r++) begin
         ch = $urandom;
         if (r % 2 == 1) ch[15:12] = ch[11:8];
         run(ch, r[0]);
      end

      repeat (5) @(negedge clk);
      check("hold_response", response, last_exp.resp);
      check("hold_tie_mask", tie_mask, last_exp.tie);
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
